// File: rtl/rp_8bit_trace_fetch.sv
// Instruction trace capture for an 8-bit RISC core: pairs 32-bit opcodes with
// their second word and queues {pc, code, ext, two} records in a small FIFO.
module rp_8bit_trace_fetch #(
   parameter int PAW    = 11,
   parameter int FDEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           pmem_ce,
   input  logic [PAW-1:0] pmem_a,
   input  logic [15:0]    pmem_d,
   input  logic           flush,
   output logic           trc_vld,
   input  logic           trc_rdy,
   output logic [PAW-1:0] trc_pc,
   output logic [15:0]    trc_code,
   output logic [15:0]    trc_ext,
   output logic           trc_two,
   output logic           ovf,
   output logic [7:0]     drop_cnt
);

   localparam int AW = $clog2(FDEPTH);
   localparam int RW = PAW + 33;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EXT  = 1'b1;

   logic           d_vld;
   logic [PAW-1:0] pc_q;
   logic [0:0]     state, next_state;
   logic [PAW-1:0] hold_pc;
   logic [15:0]    hold_code;
   logic           push;
   logic [RW-1:0]  push_rec;

   logic [RW-1:0]  mem [FDEPTH];
   logic [AW:0]    wr_ptr, rd_ptr;
   logic           empty, full, pop, wr_en;
   logic [RW-1:0]  head;

   // lds/sts (1001_00?x_xxxx_0000) and jmp/call (1001_010x_xxxx_11xx) carry a second word.
   function automatic logic is_two(input logic [15:0] w);
      return ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
             ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_vld <= 1'b0;
         pc_q  <= '0;
      end else begin
         d_vld <= pmem_ce;
         if (pmem_ce) pc_q <= pmem_a;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      push       = 1'b0;
      push_rec   = '0;
      if (flush) begin
         next_state = S_IDLE;
      end else if (d_vld) begin
         case (state)
            S_IDLE: begin
               if (is_two(pmem_d)) begin
                  next_state = S_EXT;
               end else begin
                  push     = 1'b1;
                  push_rec = {pc_q, pmem_d, 16'h0000, 1'b0};
               end
            end
            default: begin
               push       = 1'b1;
               push_rec   = {hold_pc, hold_code, pmem_d, 1'b1};
               next_state = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         hold_pc   <= '0;
         hold_code <= '0;
      end else begin
         state <= next_state;
         if ((state == S_IDLE) && d_vld && !flush && is_two(pmem_d)) begin
            hold_pc   <= pc_q;
            hold_code <= pmem_d;
         end
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && trc_rdy;
   // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push && full && !pop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   // NOTE: storage is not reset; the empty-gated head mux keeps outputs at zero after reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_rec;
   end

   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign trc_vld = !empty;
   assign {trc_pc, trc_code, trc_ext, trc_two} = head;

endmodule

// File: tb/tb_rp_8bit_trace_fetch.sv
// Directed self-checking bench for rp_8bit_trace_fetch; inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_rp_8bit_trace_fetch;

   localparam int PAW = 11;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           pmem_ce;
   logic [PAW-1:0] pmem_a;
   logic [15:0]    pmem_d;
   logic           flush;
   logic           trc_vld;
   logic           trc_rdy;
   logic [PAW-1:0] trc_pc;
   logic [15:0]    trc_code;
   logic [15:0]    trc_ext;
   logic           trc_two;
   logic           ovf;
   logic [7:0]     drop_cnt;

   int checks = 0;
   int errors = 0;

   rp_8bit_trace_fetch #(.PAW(PAW), .FDEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pmem_ce  (pmem_ce),
      .pmem_a   (pmem_a),
      .pmem_d   (pmem_d),
      .flush    (flush),
      .trc_vld  (trc_vld),
      .trc_rdy  (trc_rdy),
      .trc_pc   (trc_pc),
      .trc_code (trc_code),
      .trc_ext  (trc_ext),
      .trc_two  (trc_two),
      .ovf      (ovf),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rec(input string name, input logic vld, input logic [PAW-1:0] pc,
                             input logic [15:0] code, input logic [15:0] ext, input logic two);
      checks++;
      if (trc_vld !== vld || (vld && (trc_pc !== pc || trc_code !== code ||
                                      trc_ext !== ext || trc_two !== two))) begin
         errors++;
         $display("FAIL %s: got vld=%b pc=%h code=%h ext=%h two=%b, want vld=%b pc=%h code=%h ext=%h two=%b",
                  name, trc_vld, trc_pc, trc_code, trc_ext, trc_two, vld, pc, code, ext, two);
      end
   endtask

   task automatic expect_drop(input string name, input logic o, input logic [7:0] cnt);
      checks++;
      if (ovf !== o || drop_cnt !== cnt) begin
         errors++;
         $display("FAIL %s: got ovf=%b drop_cnt=%0d, want ovf=%b drop_cnt=%0d",
                  name, ovf, drop_cnt, o, cnt);
      end
   endtask

   // Pipelined one-word fetches: address base+i with data code_base+i the following cycle.
   task automatic fetch_stream(input int n, input logic [PAW-1:0] base, input logic [15:0] code_base);
      for (int i = 0; i <= n; i++) begin
         pmem_ce = (i < n);
         pmem_a  = base + PAW'(i);
         pmem_d  = (i > 0) ? code_base + 16'(i - 1) : 16'h0000;
         step();
      end
      pmem_ce = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pmem_ce = 1'b0; pmem_a = '0; pmem_d = '0; flush = 1'b0; trc_rdy = 1'b0;
      step(); step();
      checks++;
      if (trc_vld !== 1'b0 || trc_pc !== '0 || trc_code !== 16'h0 || trc_ext !== 16'h0 || trc_two !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got vld=%b pc=%h code=%h ext=%h two=%b, want all zero",
                  trc_vld, trc_pc, trc_code, trc_ext, trc_two);
      end
      expect_drop("reset_drop", 1'b0, 8'd0);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_one_word();
      trc_rdy = 1'b1;
      pmem_ce = 1'b1; pmem_a = 11'h010;
      step();
      pmem_ce = 1'b0; pmem_d = 16'h0000;
      expect_rec("one_word_t1", 1'b0, '0, '0, '0, 1'b0);
      step();
      expect_rec("one_word_t2", 1'b1, 11'h010, 16'h0000, 16'h0000, 1'b0);
      step();
      expect_rec("one_word_popped", 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic test_two_word();
      trc_rdy = 1'b0;
      pmem_ce = 1'b1; pmem_a = 11'h020;
      step();
      pmem_a = 11'h021; pmem_d = 16'h940C;
      step();
      pmem_ce = 1'b0; pmem_d = 16'h0123;
      expect_rec("two_word_first_held", 1'b0, '0, '0, '0, 1'b0);
      step();
      expect_rec("two_word_record", 1'b1, 11'h020, 16'h940C, 16'h0123, 1'b1);
      trc_rdy = 1'b1;
      step();
      expect_rec("two_word_single", 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic test_flush();
      trc_rdy = 1'b0;
      pmem_ce = 1'b1; pmem_a = 11'h030;
      step();
      pmem_a = 11'h031; pmem_d = 16'h9100;
      step();
      pmem_a = 11'h040; pmem_d = 16'h5555; flush = 1'b1;
      step();
      flush = 1'b0; pmem_ce = 1'b0; pmem_d = 16'h2411;
      expect_rec("flush_no_record", 1'b0, '0, '0, '0, 1'b0);
      step();
      expect_rec("flush_after", 1'b1, 11'h040, 16'h2411, 16'h0000, 1'b0);
      trc_rdy = 1'b1;
      step();
      expect_rec("flush_drained", 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic test_overflow();
      trc_rdy = 1'b0;
      fetch_stream(6, 11'h100, 16'h1000);
      expect_rec("ovf_head", 1'b1, 11'h100, 16'h1000, 16'h0000, 1'b0);
      expect_drop("ovf_count", 1'b1, 8'd2);
      step(); step();
      expect_rec("ovf_stable", 1'b1, 11'h100, 16'h1000, 16'h0000, 1'b0);
      trc_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_rec($sformatf("ovf_drain_%0d", i), 1'b1, 11'h100 + PAW'(i), 16'h1000 + 16'(i), 16'h0000, 1'b0);
         step();
      end
      expect_rec("ovf_empty", 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic test_full_push_pop();
      trc_rdy = 1'b0;
      fetch_stream(4, 11'h200, 16'h1200);
      pmem_ce = 1'b1; pmem_a = 11'h204;
      step();
      pmem_ce = 1'b0; pmem_d = 16'h1204; trc_rdy = 1'b1;
      step();
      trc_rdy = 1'b0;
      expect_drop("full_pushpop_nodrop", 1'b1, 8'd2);
      trc_rdy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         expect_rec($sformatf("full_pushpop_drain_%0d", i), 1'b1, 11'h200 + PAW'(i), 16'h1200 + 16'(i), 16'h0000, 1'b0);
         step();
      end
      expect_rec("full_pushpop_empty", 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic test_reset_mid();
      trc_rdy = 1'b0;
      fetch_stream(2, 11'h300, 16'h1300);
      pmem_ce = 1'b1; pmem_a = 11'h302;
      step();
      pmem_ce = 1'b0; pmem_d = 16'h940E;
      step();
      // Now in EXT with two records queued; a fetch is launched during reset.
      rst_n = 1'b0; pmem_ce = 1'b1; pmem_a = 11'h3FF;
      step();
      expect_rec("rst_mid_vld", 1'b0, '0, '0, '0, 1'b0);
      expect_drop("rst_mid_drop", 1'b0, 8'd0);
      rst_n = 1'b1; pmem_ce = 1'b0; pmem_d = 16'h2222;
      step();
      expect_rec("rst_mid_stale_ignored", 1'b0, '0, '0, '0, 1'b0);
      pmem_ce = 1'b1; pmem_a = 11'h050;
      step();
      pmem_ce = 1'b0; pmem_d = 16'h0001;
      step();
      expect_rec("rst_mid_idle", 1'b1, 11'h050, 16'h0001, 16'h0000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_one_word();
      test_two_word();
      test_flush();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
